// File: rtl/cdc_pkg.sv
// Shared definitions for the src2dest four-phase req/ack crossing.
// Used by both the source-side transmitter and the destination-side receiver.
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_LOW = 2'd2
    } state_e;

    localparam int DEF_DATAWIDTH   = 8;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop single-bit level synchronizer with asynchronous active-low clear.
// Shared between the transmitter (ack path) and the receiver (req path).
module cdc_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Source-side four-phase req/ack transmitter: captures one upstream word, raises
// tx_req, and waits for the synchronized ack to rise and fall before the next word.
module cdc_hs_tx
    import cdc_pkg::*;
#(
    parameter int DATAWIDTH   = DEF_DATAWIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNTWIDTH    = 16
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATAWIDTH-1:0] tx_data,
    output logic                 tx_req,
    input  logic                 tx_ack,
    output logic                 xfer_done,
    output logic [CNTWIDTH-1:0]  xfer_cnt,
    output logic                 proto_err
);

    state_e                state_q, state_d;
    logic [DATAWIDTH-1:0]  data_q, data_d;
    logic                  req_q, req_d;
    logic                  done_q, done_d;
    logic [CNTWIDTH-1:0]   cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  ack_s;
    logic                  accept;

    // tx_ack is asynchronous to CLK; nothing else in this block may look at it.
    cdc_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk_i  (CLK),
        .rst_ni (RSTn),
        .d_i    (tx_ack),
        .q_o    (ack_s)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            data_q  <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            req_q   <= req_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:     state_d = accept ? REQ : IDLE;
            REQ:      state_d = ack_s ? WAIT_LOW : REQ;
            WAIT_LOW: state_d = ack_s ? WAIT_LOW : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == IDLE) && !ack_s;
        accept   = in_valid && in_ready;
        data_d   = data_q;
        req_d    = 1'b0;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        // An ack seen with no request outstanding is latched until reset.
        err_d    = err_q | ((state_q == IDLE) && ack_s);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d = in_data;
                    req_d  = 1'b1;
                end
            end
            REQ: begin
                req_d = !ack_s;
            end
            WAIT_LOW: begin
                if (!ack_s) begin
                    done_d = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            default: begin
                req_d = 1'b0;
            end
        endcase
    end

    assign tx_data   = data_q;
    assign tx_req    = req_q;
    assign xfer_done = done_q;
    assign xfer_cnt  = cnt_q;
    assign proto_err = err_q;

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Directed bench for cdc_hs_tx with a 60 ns destination-domain ack echo model.
module tb_cdc_hs_tx;

    localparam int DW = 8;
    localparam int SS = 2;
    localparam int CW = 8;

    logic          CLK = 1'b0;
    logic          ACLK = 1'b0;
    logic          RSTn = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] tx_data;
    logic          tx_req;
    logic          tx_ack;
    logic          xfer_done;
    logic [CW-1:0] xfer_cnt;
    logic          proto_err;

    int total = 0;
    int bad = 0;

    logic [1:0] ack_mode = 2'd0;
    logic       ack_force = 1'b0;
    logic       a1 = 1'b0;
    logic       a2 = 1'b0;
    logic       req_prev = 1'b0;
    logic [DW-1:0] cap[$];

    cdc_hs_tx #(
        .DATAWIDTH   (DW),
        .SYNC_STAGES (SS),
        .CNTWIDTH    (CW)
    ) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tx_data   (tx_data),
        .tx_req    (tx_req),
        .tx_ack    (tx_ack),
        .xfer_done (xfer_done),
        .xfer_cnt  (xfer_cnt),
        .proto_err (proto_err)
    );

    always #20 CLK = ~CLK;
    always #30 ACLK = ~ACLK;

    always @(posedge ACLK) begin
        a1 <= tx_req;
        a2 <= a1;
    end

    always_comb begin
        tx_ack = 1'b0;
        case (ack_mode)
            2'd0:    tx_ack = a2;
            2'd1:    tx_ack = tx_req;
            default: tx_ack = ack_force;
        endcase
    end

    always @(negedge CLK) begin
        if (tx_req && !req_prev) cap.push_back(tx_data);
        req_prev <= tx_req;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_xfer(input logic [DW-1:0] d, input logic [DW-1:0] junk,
                           input logic hold_v, input string tag);
        int   n;
        logic seen, stab_ok, rdy_ok;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_ready_before"}, in_ready, 1);
        in_data  = d;
        in_valid = 1'b1;
        @(negedge CLK);
        check({tag, "_req_at_accept"}, tx_req, 1);
        check({tag, "_data_at_accept"}, tx_data, d);
        in_data  = junk;
        in_valid = hold_v;
        seen     = 1'b0;
        stab_ok  = 1'b1;
        rdy_ok   = 1'b1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge CLK);
            if (tx_data !== d) stab_ok = 1'b0;
            if (xfer_done === 1'b1) seen = 1'b1;
            else if (in_ready !== 1'b0) rdy_ok = 1'b0;
        end
        in_valid = 1'b0;
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_data_stable"}, stab_ok, 1);
        check({tag, "_ready_low_busy"}, rdy_ok, 1);
        check({tag, "_req_low_at_done"}, tx_req, 0);
        check({tag, "_ready_at_done"}, in_ready, 1);
    endtask

    initial begin
        logic [DW-1:0] words [3];
        logic          seen;
        int            n;
        logic [CW-1:0] c255;
        words[0] = 8'h14;
        words[1] = 8'h16;
        words[2] = 8'h0B;

        // Reset state, checked before any CLK edge
        #1 RSTn = 1'b0;
        #4;
        check("rst_req", tx_req, 0);
        check("rst_data", tx_data, 0);
        check("rst_done", xfer_done, 0);
        check("rst_cnt", xfer_cnt, 0);
        check("rst_err", proto_err, 0);
        check("rst_ready", in_ready, 1);
        #6 RSTn = 1'b1;

        // Single transfer with the slow ack echo
        @(negedge CLK);
        do_xfer(8'h02, 8'hFF, 1'b0, "single");
        check("single_cnt", xfer_cnt, 1);
        @(negedge CLK);
        check("single_done_one_cycle", xfer_done, 0);
        check("single_cnt_hold", xfer_cnt, 1);

        // Data stability: in_data forced to 0xFF and in_valid high while busy
        do_xfer(8'h5A, 8'hFF, 1'b1, "stable");
        check("stable_cnt", xfer_cnt, 2);
        check("stable_no_reaccept", tx_req, 0);

        // Back-to-back stream with in_valid held high
        @(negedge CLK);
        cap.delete();
        in_data  = words[0];
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            seen = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
                @(negedge CLK);
                if (xfer_done === 1'b1) seen = 1'b1;
            end
            check("stream_done_seen", seen, 1);
            if (k < 2) in_data = words[k+1];
            else in_valid = 1'b0;
        end
        repeat (3) @(negedge CLK);
        check("stream_cnt", xfer_cnt, 5);
        check("stream_idle_req", tx_req, 0);
        check("stream_words", cap.size(), 3);
        for (int k = 0; k < 3; k++) begin
            check("stream_word", (cap.size() > k) ? cap[k] : 8'hxx, words[k]);
        end

        // Spurious ack while IDLE
        ack_mode  = 2'd2;
        ack_force = 1'b1;
        @(negedge CLK);
        check("spur_ready_one_stage", in_ready, 1);
        check("spur_err_early", proto_err, 0);
        @(negedge CLK);
        check("spur_ready_gated", in_ready, 0);
        in_data  = 8'h33;
        in_valid = 1'b1;
        @(negedge CLK);
        check("spur_err_set", proto_err, 1);
        check("spur_no_accept", tx_req, 0);
        @(negedge CLK);
        check("spur_no_accept2", tx_req, 0);
        in_valid  = 1'b0;
        ack_force = 1'b0;
        repeat (3) @(negedge CLK);
        check("spur_ready_back", in_ready, 1);
        check("spur_err_sticky", proto_err, 1);
        check("spur_cnt", xfer_cnt, 5);
        ack_mode = 2'd0;

        // Reset while in REQ
        in_data  = 8'h77;
        in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        check("midrst_req_before", tx_req, 1);
        #5 RSTn = 1'b0;
        #1;
        check("midrst_req", tx_req, 0);
        check("midrst_cnt", xfer_cnt, 0);
        check("midrst_data", tx_data, 0);
        check("midrst_err", proto_err, 0);
        #300 RSTn = 1'b1;
        repeat (3) @(negedge CLK);
        check("midrst_ready_after", in_ready, 1);
        check("midrst_err_after", proto_err, 0);
        do_xfer(8'h3C, 8'hFF, 1'b0, "postrst");
        check("postrst_cnt", xfer_cnt, 1);

        // Counter wrap with instant ack echo
        @(negedge CLK);
        #5 RSTn = 1'b0;
        #5 RSTn = 1'b1;
        @(negedge CLK);
        check("wrap_start_cnt", xfer_cnt, 0);
        ack_mode = 2'd1;
        in_data  = 8'hA5;
        in_valid = 1'b1;
        n    = 0;
        c255 = '0;
        for (int i = 0; i < 256 * 10 && n < 256; i++) begin
            @(negedge CLK);
            if (xfer_done === 1'b1) begin
                n++;
                if (n == 255) c255 = xfer_cnt;
            end
        end
        in_valid = 1'b0;
        check("wrap_pulses", n, 256);
        check("wrap_cnt_max", c255, 8'hFF);
        check("wrap_cnt_zero", xfer_cnt, 0);
        check("wrap_err", proto_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
